// File: rtl/imem_loader.sv
// imem_loader: writer side of the instruction memory.
// It accepts a framed byte stream: a 16-bit little-endian word count N, then 4*N data bytes.
// It assembles little-endian 32-bit words and writes them to a word-aligned port from BASE_ADDR.
// The core is held in reset while a load is running or after a failed load.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: one trailing byte must equal the XOR of all
// data bytes. A mismatch sends the loader to ERR. Writes already issued are not undone.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERR} state_t;
`endif

  state_t      state_q;
  logic [7:0]  len_lo_q;
  logic [15:0] len_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] buf_q;
  logic        in_ready_q;
  logic        imem_we_q;
  logic [31:0] imem_waddr_q;
  logic [31:0] imem_wdata_q;
  logic        core_hold_q;
  logic        load_done_q;
  logic        load_error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  logic        accept_d;
  logic [15:0] len_rx_d;
  logic        len_bad_d;
  logic        last_word_d;
  logic [31:0] word_d;
  logic [31:0] waddr_d;

  // Handshake, received length and the word/address about to be written.
  always_comb begin
    accept_d    = in_valid && in_ready_q;
    len_rx_d    = {in_data, len_lo_q};
    len_bad_d   = (len_rx_d == 16'd0) || ({16'd0, len_rx_d} > DEPTH_W);
    last_word_d = (word_idx_q == (len_q - 16'd1));
    word_d      = {in_data, buf_q};
    waddr_d     = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
  end

  // Loader FSM. All outputs are registered and updated on the transition that implies them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      buf_q        <= '0;
      in_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= BASE_ADDR;
      imem_wdata_q <= '0;
      core_hold_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      imem_we_q   <= 1'b0;
      load_done_q <= 1'b0;
      case (state_q)
        IDLE, ERR: begin
          if (load_start) begin
            state_q      <= LEN0;
            core_hold_q  <= 1'b1;
            load_error_q <= 1'b0;
            in_ready_q   <= 1'b1;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
          end
        end
        LEN0: begin
          if (accept_d) begin
            len_lo_q <= in_data;
            state_q  <= LEN1;
          end
        end
        LEN1: begin
          if (accept_d) begin
            if (len_bad_d) begin
              state_q      <= ERR;
              in_ready_q   <= 1'b0;
              load_error_q <= 1'b1;
            end else begin
              len_q   <= len_rx_d;
              state_q <= DATA;
            end
          end
        end
        DATA: begin
          if (accept_d) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            buf_q      <= {in_data, buf_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ in_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_waddr_q <= waddr_d;
              imem_wdata_q <= word_d;
              if (last_word_d) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_q    <= CHK;
`else
                state_q    <= DONE;
                in_ready_q <= 1'b0;
`endif
              end else begin
                word_idx_q <= word_idx_q + 16'd1;
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept_d) begin
            in_ready_q <= 1'b0;
            if (in_data == csum_q) begin
              state_q <= DONE;
            end else begin
              state_q      <= ERR;
              load_error_q <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          // The final write pulse occupies this cycle; completion is flagged one cycle later.
          load_done_q <= 1'b1;
          core_hold_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule
